mesh_router: RTL and testbench

Parametrised five-port mesh router that replaces the fixed three-, four- and five-port node variants with one module. Each instance is told its (X,Y) position and the mesh size, and it disables any port that faces off the mesh edge. Single-flit packets are buffered per input, routed dimension-order (X then Y), and arbitrated round-robin per output. Outputs use a registered valid/ready handshake. A top-level mesh instantiates ROWS×COLS copies of this block and wires neighbouring E/W and N/S ports together.

---
 rtl/mesh_router.sv | 181 ++++++++++++++++++
 tb/tb_mesh_router.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_router.sv
// mesh_router: five-port mesh node (L, N, E, S, W) for a COLS x ROWS mesh.
// Each node knows its (X,Y) position and disables ports that face off the
// mesh edge. Single-flit packets are queued per input, routed X-then-Y, and
// granted round-robin per output into a registered valid/ready stage.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_flit      per-port input flit, slice p = [p*FLIT_W +: FLIT_W]
//   in_ready              per-port input ready (0 on disabled ports / reset)
//   out_valid/out_flit    per-port registered output
//   out_ready             per-port downstream ready
//   drop_count            saturating count of out-of-range flits discarded
// Port index: 0=L 1=N 2=E 3=S 4=W.
// Flit: [FLIT_W-1 -: XW] dest_x, then YW bits dest_y, [DATA_W-1:0] payload.
module mesh_router #(
  parameter int COLS   = 4,
  parameter int ROWS   = 4,
  parameter int X      = 0,
  parameter int Y      = 0,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int XW     = ($clog2(COLS) > 1) ? $clog2(COLS) : 1,
  localparam int YW     = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1,
  localparam int FLIT_W = XW + YW + DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          in_valid,
  input  logic [5*FLIT_W-1:0] in_flit,
  output logic [4:0]          in_ready,
  output logic [4:0]          out_valid,
  output logic [5*FLIT_W-1:0] out_flit,
  input  logic [4:0]          out_ready,
  output logic [15:0]         drop_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int P_L = 0;
  localparam int P_N = 1;
  localparam int P_E = 2;
  localparam int P_S = 3;
  localparam int P_W = 4;

  // Bit 5 flags an out-of-range destination; bits 4:0 are a one-hot port.
  function automatic logic [5:0] route_of(input logic [XW-1:0] dx,
                                          input logic [YW-1:0] dy);
    logic [5:0] r;
    r = '0;
    if (32'(dx) >= 32'(COLS) || 32'(dy) >= 32'(ROWS)) r[5]   = 1'b1;
    else if (32'(dx) > 32'(X))                        r[P_E] = 1'b1;
    else if (32'(dx) < 32'(X))                        r[P_W] = 1'b1;
    else if (32'(dy) > 32'(Y))                        r[P_S] = 1'b1;
    else if (32'(dy) < 32'(Y))                        r[P_N] = 1'b1;
    else                                              r[P_L] = 1'b1;
    return r;
  endfunction

  logic [4:0]        w_en;
  logic [4:0]        w_full;
  logic [4:0]        w_live;
  logic [4:0]        w_push;
  logic [4:0]        w_pop;
  logic [4:0]        w_drop;
  logic [FLIT_W-1:0] w_head [5];
  logic [5:0]        w_rt   [5];
  logic [4:0]        w_req  [5];  // indexed [input][output]
  logic [4:0]        w_gnt  [5];  // indexed [output][input]
  logic [2:0]        w_gidx [5];
  logic [4:0]        w_hit;
  logic [FLIT_W-1:0] w_sel  [5];
  logic [2:0]        w_ndrop;
  logic [16:0]       w_dsum;

  logic [FLIT_W-1:0] r_mem [5][DEPTH];
  logic [AW-1:0]     r_rd  [5];
  logic [AW-1:0]     r_wr  [5];
  logic [AW:0]       r_cnt [5];
  logic [4:0]        r_ov;
  logic [FLIT_W-1:0] r_of  [5];
  logic [2:0]        r_ptr [5];
  logic [15:0]       r_drop;

  assign w_en = {(X > 0), (Y < ROWS - 1), (X < COLS - 1), (Y > 0), 1'b1};

  assign in_ready   = w_en & ~w_full & {5{~reset}};
  assign w_push     = in_valid & in_ready;
  assign out_valid  = r_ov;
  assign drop_count = r_drop;

  for (genvar gi = 0; gi < 5; gi++) begin : g_in
    // DEPTH is a power of two, so the count MSB alone means full.
    assign w_full[gi] = r_cnt[gi][AW];
    assign w_live[gi] = w_en[gi] && (r_cnt[gi] != '0);
    assign w_head[gi] = r_mem[gi][r_rd[gi]];
    assign w_rt[gi]   = route_of(w_head[gi][FLIT_W-1 -: XW],
                                 w_head[gi][DATA_W +: YW]);
    assign w_drop[gi] = w_live[gi] && w_rt[gi][5];
    assign w_req[gi]  = (w_live[gi] && !w_rt[gi][5]) ? (w_rt[gi][4:0] & w_en) : '0;
    assign out_flit[gi*FLIT_W +: FLIT_W] = r_of[gi];
  end

  // Round-robin grant per output, searching from last winner + 1.
  // Each head requests exactly one output, so an input wins at most once.
  always_comb begin
    logic [2:0] idx;
    idx = '0;
    for (int unsigned o = 0; o < 5; o++) begin
      w_gnt[o]  = '0;
      w_gidx[o] = '0;
      w_hit[o]  = 1'b0;
      w_sel[o]  = '0;
      if (!r_ov[o] || out_ready[o]) begin
        for (int unsigned k = 1; k <= 5; k++) begin
          idx = 3'((32'(r_ptr[o]) + k) % 5);
          if (!w_hit[o] && w_req[idx][o]) begin
            w_hit[o]      = 1'b1;
            w_gnt[o][idx] = 1'b1;
            w_gidx[o]     = idx;
            w_sel[o]      = w_head[idx];
          end
        end
      end
    end
  end

  always_comb begin
    w_pop   = w_drop;
    w_ndrop = '0;
    for (int unsigned o = 0; o < 5; o++) w_pop = w_pop | w_gnt[o];
    for (int unsigned i = 0; i < 5; i++) w_ndrop = w_ndrop + 3'(w_drop[i]);
  end

  assign w_dsum = {1'b0, r_drop} + 17'(w_ndrop);

  // FIFO storage: no reset needed, validity is tracked by the counters.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 5; i++) begin
      if (w_push[i]) r_mem[i][r_wr[i]] <= in_flit[i*FLIT_W +: FLIT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 5; i++) begin
        r_rd[i]  <= '0;
        r_wr[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 5; i++) begin
        if (w_push[i]) r_wr[i] <= r_wr[i] + 1'b1;
        if (w_pop[i])  r_rd[i] <= r_rd[i] + 1'b1;
        if (w_push[i] && !w_pop[i])      r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (!w_push[i] && w_pop[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ov   <= '0;
      r_drop <= '0;
      for (int unsigned o = 0; o < 5; o++) begin
        r_of[o]  <= '0;
        r_ptr[o] <= 3'd4;
      end
    end else begin
      r_drop <= w_dsum[16] ? '1 : w_dsum[15:0];
      for (int unsigned o = 0; o < 5; o++) begin
        if (!r_ov[o] || out_ready[o]) begin
          r_ov[o] <= w_hit[o];
          if (w_hit[o]) begin
            r_of[o]  <= w_sel[o];
            r_ptr[o] <= w_gidx[o];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mesh_router.sv
// Testbench for mesh_router: directed cases on a 4x4 interior node, a corner
// node and a 3-column node, plus a randomized run on the 3-column node
// scored against per-(input,output) ordered queues built from routing rules.
module tb_mesh_router;

  localparam int FW = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]      in_valid_a = '0, in_ready_a, out_valid_a, out_ready_a = '1;
  logic [5*FW-1:0] in_flit_a = '0, out_flit_a;
  logic [15:0]     drop_count_a;
  logic [4:0]      in_valid_b = '0, in_ready_b, out_valid_b, out_ready_b = '1;
  logic [5*FW-1:0] in_flit_b = '0, out_flit_b;
  logic [15:0]     drop_count_b;
  logic [4:0]      in_valid_c = '0, in_ready_c, out_valid_c, out_ready_c = '1;
  logic [5*FW-1:0] in_flit_c = '0, out_flit_c;
  logic [15:0]     drop_count_c;

  mesh_router #(.COLS(4), .ROWS(4), .X(1), .Y(1), .DATA_W(8), .DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_flit(in_flit_a),
    .in_ready(in_ready_a), .out_valid(out_valid_a), .out_flit(out_flit_a),
    .out_ready(out_ready_a), .drop_count(drop_count_a));

  mesh_router #(.COLS(4), .ROWS(4), .X(0), .Y(0), .DATA_W(8), .DEPTH(4)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_flit(in_flit_b),
    .in_ready(in_ready_b), .out_valid(out_valid_b), .out_flit(out_flit_b),
    .out_ready(out_ready_b), .drop_count(drop_count_b));

  mesh_router #(.COLS(3), .ROWS(4), .X(1), .Y(1), .DATA_W(8), .DEPTH(4)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid_c), .in_flit(in_flit_c),
    .in_ready(in_ready_c), .out_valid(out_valid_c), .out_flit(out_flit_c),
    .out_ready(out_ready_c), .drop_count(drop_count_c));

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] mk(input int x, input int y, input int d);
    return {x[1:0], y[1:0], d[7:0]};
  endfunction

  // Dimension-order routing rule: -1 means the flit is dropped.
  function automatic int route(input int dx, input int dy, input int x, input int y,
                               input int cols, input int rows);
    if (dx >= cols || dy >= rows) return -1;
    if (dx > x) return 2;
    if (dx < x) return 4;
    if (dy > y) return 3;
    if (dy < y) return 1;
    return 0;
  endfunction

  logic [FW-1:0] sb [25][$];
  logic [FW-1:0] inq [5];
  logic [FW-1:0] oq  [5];
  logic [4:0]    acc, fire, hold;
  int            exp_drop;
  int            seq;
  int            n_acc;

  initial begin
    // Reset state
    tick();
    check("rst_in_ready", 32'(in_ready_a), 0);
    tick();
    check("rst_out_valid", 32'(out_valid_a), 0);
    check("rst_out_flit", 32'(out_flit_a[31:0]), 0);
    check("rst_drop", 32'(drop_count_a), 0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", 32'(in_ready_a), 32'h1F);

    // Single hop to E: two-cycle latency, no other outputs
    in_valid_a = 5'b00001;
    in_flit_a[0 +: FW] = mk(3, 1, 8'hA5);
    tick();
    in_valid_a = '0;
    check("lat_early", 32'(out_valid_a), 0);
    tick();
    check("e_valid", 32'(out_valid_a), 32'b00100);
    check("e_flit", 32'(out_flit_a[2*FW +: FW]), 32'(mk(3, 1, 8'hA5)));
    tick();
    check("e_clear", 32'(out_valid_a), 0);

    // Local delivery
    in_valid_a = 5'b00001;
    in_flit_a[0 +: FW] = mk(1, 1, 8'h3C);
    tick();
    in_valid_a = '0;
    tick();
    check("l_valid", 32'(out_valid_a), 32'b00001);
    check("l_flit", 32'(out_flit_a[0 +: FW]), 32'(mk(1, 1, 8'h3C)));
    tick();

    // Round-robin from fresh pointers: L, N, W in order
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid_a = 5'b10011;
    in_flit_a[0*FW +: FW] = mk(3, 1, 8'h10);
    in_flit_a[1*FW +: FW] = mk(3, 1, 8'h11);
    in_flit_a[4*FW +: FW] = mk(3, 1, 8'h14);
    tick();
    in_valid_a = '0;
    tick();
    check("rr_0", 32'(out_flit_a[2*FW +: FW]), 32'(mk(3, 1, 8'h10)));
    check("rr_0v", 32'(out_valid_a[2]), 1);
    tick();
    check("rr_1", 32'(out_flit_a[2*FW +: FW]), 32'(mk(3, 1, 8'h11)));
    check("rr_1v", 32'(out_valid_a[2]), 1);
    tick();
    check("rr_2", 32'(out_flit_a[2*FW +: FW]), 32'(mk(3, 1, 8'h14)));
    check("rr_2v", 32'(out_valid_a[2]), 1);
    tick();

    // Backpressure capacity: FIFO plus output register
    out_ready_a = 5'b11011;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      logic rdy;
      in_valid_a = 5'b00001;
      in_flit_a[0 +: FW] = mk(3, 1, n_acc);
      rdy = in_ready_a[0];
      tick();
      if (rdy) n_acc++;
    end
    in_valid_a = '0;
    check("cap_count", 32'(n_acc), 5);
    check("cap_ready", 32'(in_ready_a[0]), 0);
    out_ready_a = '1;
    for (int k = 0; k < 5; k++) begin
      check("drain_v", 32'(out_valid_a[2]), 1);
      check("drain_f", 32'(out_flit_a[2*FW +: FW]), 32'(mk(3, 1, k)));
      tick();
    end
    check("drain_end", 32'(out_valid_a[2]), 0);

    // Corner node: N and W are disabled
    for (int c = 0; c < 8; c++) begin
      in_valid_b = 5'b10011;
      in_flit_b[0*FW +: FW] = mk(0, 0, c);
      in_flit_b[1*FW +: FW] = mk(1, 1, 8'hEE);
      in_flit_b[4*FW +: FW] = mk(1, 1, 8'hEE);
      check("edge_rdy", 32'(in_ready_b & 5'b10010), 0);
      tick();
      check("edge_ov", 32'(out_valid_b & 5'b11110), 0);
      if (c >= 1) check("edge_l", 32'(out_flit_b[0 +: FW]), 32'(mk(0, 0, c - 1)));
    end
    in_valid_b = '0;

    // Out-of-range drop on 3-column node
    in_valid_c = 5'b00001;
    in_flit_c[0 +: FW] = mk(3, 1, 8'h11);
    tick();
    in_valid_c = '0;
    check("drop_ov0", 32'(out_valid_c), 0);
    tick();
    check("drop_ov1", 32'(out_valid_c), 0);
    check("drop_cnt", 32'(drop_count_c), 1);
    in_valid_c = 5'b00001;
    in_flit_c[0 +: FW] = mk(2, 1, 8'h22);
    tick();
    in_valid_c = '0;
    tick();
    check("after_drop_v", 32'(out_valid_c), 32'b00100);
    check("after_drop_f", 32'(out_flit_c[2*FW +: FW]), 32'(mk(2, 1, 8'h22)));
    tick();

    // Randomized traffic on the 3-column node
    exp_drop = 1;
    seq = 0;
    for (int cyc = 0; cyc < 560; cyc++) begin
      for (int p = 0; p < 5; p++) begin
        in_valid_c[p] = (cyc < 500) && ($urandom_range(0, 2) != 0);
        in_flit_c[p*FW +: FW] = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                                 3'(p), 5'(seq)};
        seq++;
        out_ready_c[p] = (cyc >= 500) || ($urandom_range(0, 3) != 0);
      end
      acc  = in_valid_c & in_ready_c;
      fire = out_valid_c & out_ready_c;
      hold = out_valid_c & ~out_ready_c;
      for (int p = 0; p < 5; p++) begin
        inq[p] = in_flit_c[p*FW +: FW];
        oq[p]  = out_flit_c[p*FW +: FW];
      end
      tick();
      for (int p = 0; p < 5; p++) begin
        if (acc[p]) begin
          int r;
          r = route(int'(inq[p][11:10]), int'(inq[p][9:8]), 1, 1, 3, 4);
          if (r < 0) exp_drop++;
          else sb[p*5 + r].push_back(inq[p]);
        end
      end
      for (int o = 0; o < 5; o++) begin
        if (fire[o]) begin
          int src;
          src = int'(oq[o][7:5]);
          if (src > 4 || sb[(src % 5)*5 + o].size() == 0)
            check("unexpected_out", 0, 1);
          else
            check("order", 32'(oq[o]), 32'(sb[src*5 + o].pop_front()));
        end
        if (hold[o]) begin
          check("hold_v", 32'(out_valid_c[o]), 1);
          check("hold_f", 32'(out_flit_c[o*FW +: FW]), 32'(oq[o]));
        end
      end
    end
    begin
      int left;
      left = 0;
      for (int k = 0; k < 25; k++) left += sb[k].size();
      check("sb_empty", 32'(left), 0);
      check("drops", 32'(drop_count_c), 32'(exp_drop));
    end
    in_valid_c  = '0;
    out_ready_c = '1;

    // Mid-operation reset flushes buffered flits and pointers
    out_ready_a = 5'b11011;
    for (int k = 0; k < 3; k++) begin
      in_valid_a = 5'b00001;
      in_flit_a[0 +: FW] = mk(3, 1, 8'h40 + k);
      tick();
    end
    in_valid_a = '0;
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(in_ready_a), 0);
    tick();
    reset = 1'b0;
    out_ready_a = '1;
    check("mid_rst_ov", 32'(out_valid_a), 0);
    check("mid_rst_of", 32'(out_flit_a[2*FW +: FW]), 0);
    check("mid_rst_drop", 32'(drop_count_c), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("flushed", 32'(out_valid_a), 0);
    end
    in_valid_a = 5'b00011;
    in_flit_a[0*FW +: FW] = mk(3, 1, 8'h50);
    in_flit_a[1*FW +: FW] = mk(3, 1, 8'h51);
    tick();
    in_valid_a = '0;
    tick();
    check("post_rst_l", 32'(out_flit_a[2*FW +: FW]), 32'(mk(3, 1, 8'h50)));
    tick();
    check("post_rst_n", 32'(out_flit_a[2*FW +: FW]), 32'(mk(3, 1, 8'h51)));
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
